// File: rtl/lcd_sink_pkg.sv
// Shared types and field helpers for the LCD stream sink.
// Pixels are packed {R,G,B}; FIFO entries carry the frame-start flag above the pixel.
package lcd_sink_pkg;

    typedef enum logic [1:0] {
        SEARCH     = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } sinkState_t;

    localparam int PIXEL_W = 24;
    localparam int ENTRY_W = PIXEL_W + 1;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    function automatic logic [7:0] redOf(input logic [PIXEL_W-1:0] pix);
        return pix[R_HI:R_LO];
    endfunction

    function automatic logic [7:0] greenOf(input logic [PIXEL_W-1:0] pix);
        return pix[G_HI:G_LO];
    endfunction

    function automatic logic [7:0] blueOf(input logic [PIXEL_W-1:0] pix);
        return pix[B_HI:B_LO];
    endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on rdData whenever not empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
import lcd_sink_pkg::*;

module lcd_sync_fifo #(
    parameter int AW = 10,
    parameter int W  = ENTRY_W
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          push,
    input  logic [W-1:0]  wrData,
    input  logic          pop,
    output logic [W-1:0]  rdData,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    // count can only reach 2^AW, so its top bit alone marks full
    assign empty  = (count == '0);
    assign full   = count[AW];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    always_ff @(posedge iCLK) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_stream_sink.sv
// Buffers an SOP-framed RGB stream and releases it one pixel per DEN cycle,
// locked so that the stream's SOP pixel lands on the timing controller's X=0,Y=0.
import lcd_sink_pkg::*;

module lcd_stream_sink #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int FIFO_AW  = 10
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [23:0] iST_DATA,
    input  logic        iST_VALID,
    input  logic        iST_SOP,
    input  logic        iST_EOP,
    output logic        oST_READY,
    input  logic        iHD,
    input  logic        iVD,
    input  logic        iDEN,
    input  logic [10:0] iLCD_X,
    input  logic [9:0]  iLCD_Y,
    output logic        oHD,
    output logic        oVD,
    output logic        oDEN,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oLOCKED,
    output logic        oUNDERFLOW,
    output logic        oSYNC_LOST
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W     = $clog2(FRAME_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

    sinkState_t         state;
    sinkState_t         stateNext;
    logic [CNT_W-1:0]   pixCnt;
    logic [CNT_W-1:0]   pixCntNext;
    logic               lostFrame;
    logic               lostFrameNext;
    logic               pop;
    logic               push;
    logic [PIXEL_W-1:0] pixNext;
    logic [PIXEL_W-1:0] pixReg;
    logic               underflowSet;
    logic               syncLostNext;

    logic [ENTRY_W-1:0] fifoHead;
    logic               fifoEmpty;
    logic               fifoFull;
    logic [FIFO_AW:0]   fifoCount;
    logic               headSop;
    logic [PIXEL_W-1:0] headData;
    logic               unusedSignals;

    assign headSop       = fifoHead[ENTRY_W-1];
    assign headData      = fifoHead[PIXEL_W-1:0];
    assign unusedSignals = ^{iST_EOP, fifoCount};

    // A pop this cycle frees a slot, so upstream may refill it in the same cycle
    assign oST_READY = iRST_n && (!fifoFull || pop);
    assign push      = iST_VALID && oST_READY;
    assign oLOCKED   = (state == RUN);

    lcd_sync_fifo #(
        .AW (FIFO_AW),
        .W  (ENTRY_W)
    ) uFifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .push   (push),
        .wrData ({iST_SOP, iST_DATA}),
        .pop    (pop),
        .rdData (fifoHead),
        .empty  (fifoEmpty),
        .full   (fifoFull),
        .count  (fifoCount)
    );

    always_comb begin
        stateNext     = state;
        pixCntNext    = pixCnt;
        lostFrameNext = lostFrame;
        pop           = 1'b0;
        pixNext       = '0;
        underflowSet  = 1'b0;
        syncLostNext  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (!fifoEmpty) begin
                    if (headSop) begin
                        stateNext = WAIT_FRAME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            WAIT_FRAME: begin
                if (iDEN && iLCD_X == '0 && iLCD_Y == '0) begin
                    stateNext  = RUN;
                    pop        = 1'b1;
                    pixNext    = headData;
                    pixCntNext = CNT_W'(1);
                end
            end
            RUN: begin
                if (iDEN) begin
                    pixCntNext = pixCnt + 1'b1;
                    // A frame cut short by a new SOP stays black until its last pixel
                    if (lostFrame) begin
                        pixNext = '0;
                    end else if (fifoEmpty) begin
                        underflowSet = 1'b1;
                    end else if (headSop && pixCnt != '0) begin
                        syncLostNext  = 1'b1;
                        lostFrameNext = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pixNext = headData;
                    end
                    if (pixCnt == LAST_PIX) begin
                        pixCntNext    = '0;
                        lostFrameNext = 1'b0;
                        stateNext     = (lostFrame || syncLostNext) ? WAIT_FRAME : SEARCH;
                    end
                end
            end
            default: begin
                stateNext = SEARCH;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= SEARCH;
            pixCnt    <= '0;
            lostFrame <= 1'b0;
        end else begin
            state     <= stateNext;
            pixCnt    <= pixCntNext;
            lostFrame <= lostFrameNext;
        end
    end

    // Syncs and pixel share one register stage so the panel sees them aligned
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHD        <= 1'b0;
            oVD        <= 1'b0;
            oDEN       <= 1'b0;
            pixReg     <= '0;
            oUNDERFLOW <= 1'b0;
            oSYNC_LOST <= 1'b0;
        end else begin
            oHD        <= iHD;
            oVD        <= iVD;
            oDEN       <= iDEN;
            pixReg     <= pixNext;
            oUNDERFLOW <= oUNDERFLOW || underflowSet;
            oSYNC_LOST <= syncLostNext;
        end
    end

    assign oLCD_R = oDEN ? redOf(pixReg)   : 8'd0;
    assign oLCD_G = oDEN ? greenOf(pixReg) : 8'd0;
    assign oLCD_B = oDEN ? blueOf(pixReg)  : 8'd0;

endmodule

// File: tb/tb_lcd_stream_sink.sv
// Directed bench for lcd_stream_sink on a tiny 8x4 panel with a 16-entry FIFO.
// A queue feeds the stream side; each step drives one pixel-clock cycle of timing.
module tb_lcd_stream_sink;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = 4;
    localparam int NPIX = H * V;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic [23:0] iST_DATA;
    logic        iST_VALID;
    logic        iST_SOP;
    logic        iST_EOP;
    logic        oST_READY;
    logic        iHD;
    logic        iVD;
    logic        iDEN;
    logic [10:0] iLCD_X;
    logic [9:0]  iLCD_Y;
    logic        oHD;
    logic        oVD;
    logic        oDEN;
    logic [7:0]  oLCD_R;
    logic [7:0]  oLCD_G;
    logic [7:0]  oLCD_B;
    logic        oLOCKED;
    logic        oUNDERFLOW;
    logic        oSYNC_LOST;

    int          checks = 0;
    int          failures = 0;
    int          syncLostCount = 0;
    logic [24:0] streamQ[$];
    logic        readyMid;
    logic [23:0] expPix[NPIX];

    lcd_stream_sink #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .FIFO_AW  (AW)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iST_DATA   (iST_DATA),
        .iST_VALID  (iST_VALID),
        .iST_SOP    (iST_SOP),
        .iST_EOP    (iST_EOP),
        .oST_READY  (oST_READY),
        .iHD        (iHD),
        .iVD        (iVD),
        .iDEN       (iDEN),
        .iLCD_X     (iLCD_X),
        .iLCD_Y     (iLCD_Y),
        .oHD        (oHD),
        .oVD        (oVD),
        .oDEN       (oDEN),
        .oLCD_R     (oLCD_R),
        .oLCD_G     (oLCD_G),
        .oLCD_B     (oLCD_B),
        .oLOCKED    (oLOCKED),
        .oUNDERFLOW (oUNDERFLOW),
        .oSYNC_LOST (oSYNC_LOST)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive timing and the queue head, note READY mid-cycle, sample after the edge
    task automatic applyStimulus(input logic den, input logic [10:0] x, input logic [9:0] y,
                                 input logic hd, input logic vd);
        iDEN   = den;
        iLCD_X = x;
        iLCD_Y = y;
        iHD    = hd;
        iVD    = vd;
        if (streamQ.size() > 0) begin
            iST_VALID = 1'b1;
            {iST_SOP, iST_DATA} = streamQ[0];
            iST_EOP = 1'b0;
        end else begin
            iST_VALID = 1'b0;
            iST_SOP   = 1'b0;
            iST_DATA  = '0;
            iST_EOP   = 1'b0;
        end
        #3;
        readyMid = oST_READY;
        if (iST_VALID && oST_READY) begin
            void'(streamQ.pop_front());
        end
        @(posedge iCLK);
        #1;
        syncLostCount += int'(oSYNC_LOST);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 11'd0, 10'd0, 1'b1, 1'b1);
        end
    endtask

    task automatic queueWords(input logic [23:0] base, input int n, input bit withSop);
        for (int i = 0; i < n; i++) begin
            streamQ.push_back({(withSop && i == 0), base + 24'(i)});
        end
    endtask

    task automatic setExp(input logic [23:0] base, input int n);
        for (int i = 0; i < NPIX; i++) begin
            expPix[i] = (i < n) ? base + 24'(i) : 24'd0;
        end
    endtask

    // Full frame: H active + 4 blank cycles per line, V active + 2 blank lines
    task automatic playFrame(input bit chkReady);
        for (int y = 0; y < V + 2; y++) begin
            for (int x = 0; x < H + 4; x++) begin
                logic den;
                logic hd;
                logic vd;
                logic [23:0] expRgb;
                den = (y < V) && (x < H);
                hd  = (x != H);
                vd  = (y != V);
                applyStimulus(den, den ? 11'(x) : 11'd0, den ? 10'(y) : 10'd0, hd, vd);
                expRgb = den ? expPix[y * H + x] : 24'd0;
                checkOutput("oDEN", 32'(oDEN), 32'(den));
                checkOutput("oHD", 32'(oHD), 32'(hd));
                checkOutput("oVD", 32'(oVD), 32'(vd));
                checkOutput($sformatf("rgb y%0d x%0d", y, x), 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(expRgb));
                if (x == 0 && y == 0) begin
                    checkOutput("lockedAtFirstPixel", 32'(oLOCKED), 32'd1);
                    if (chkReady) begin
                        checkOutput("readyOnFirstPop", 32'(readyMid), 32'd1);
                    end
                end
            end
        end
    endtask

    initial begin
        iRST_n    = 1'b0;
        iST_DATA  = '0;
        iST_VALID = 1'b0;
        iST_SOP   = 1'b0;
        iST_EOP   = 1'b0;
        iHD       = 1'b0;
        iVD       = 1'b0;
        iDEN      = 1'b0;
        iLCD_X    = '0;
        iLCD_Y    = '0;
        readyMid  = 1'b0;

        repeat (2) @(posedge iCLK);
        #1;
        checkOutput("rstDEN", 32'(oDEN), 32'd0);
        checkOutput("rstLocked", 32'(oLOCKED), 32'd0);
        checkOutput("rstUnderflow", 32'(oUNDERFLOW), 32'd0);
        checkOutput("rstSyncLost", 32'(oSYNC_LOST), 32'd0);
        checkOutput("rstRgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
        iRST_n = 1'b1;
        idle(1);
        checkOutput("readyAfterReset", 32'(readyMid), 32'd1);

        $display("[TB] clean frame with data = index");
        queueWords(24'h000000, NPIX, 1'b1);
        setExp(24'h000000, NPIX);
        idle(30);
        checkOutput("readyWhileFullWaiting", 32'(readyMid), 32'd0);
        checkOutput("lockedWhileWaiting", 32'(oLOCKED), 32'd0);
        playFrame(1'b1);
        checkOutput("underflowClean", 32'(oUNDERFLOW), 32'd0);
        checkOutput("lockedAfterFrame1", 32'(oLOCKED), 32'd0);

        $display("[TB] garbage before SOP is discarded");
        queueWords(24'hBAD000, 3, 1'b0);
        queueWords(24'h100000, NPIX, 1'b1);
        setExp(24'h100000, NPIX);
        idle(30);
        playFrame(1'b0);
        checkOutput("underflowAfterGarbage", 32'(oUNDERFLOW), 32'd0);

        $display("[TB] short frame starves the FIFO");
        queueWords(24'h200000, 20, 1'b1);
        setExp(24'h200000, 20);
        idle(30);
        checkOutput("underflowBeforeShort", 32'(oUNDERFLOW), 32'd0);
        playFrame(1'b0);
        checkOutput("underflowAfterShort", 32'(oUNDERFLOW), 32'd1);
        checkOutput("lockedAfterShort", 32'(oLOCKED), 32'd0);

        $display("[TB] early SOP cuts a frame");
        queueWords(24'h300000, 10, 1'b1);
        queueWords(24'h400000, NPIX, 1'b1);
        setExp(24'h300000, 10);
        idle(30);
        checkOutput("syncLostBefore", 32'(syncLostCount), 32'd0);
        playFrame(1'b0);
        checkOutput("syncLostOnce", 32'(syncLostCount), 32'd1);
        checkOutput("lockedAfterCut", 32'(oLOCKED), 32'd0);
        setExp(24'h400000, NPIX);
        playFrame(1'b0);
        checkOutput("syncLostStillOnce", 32'(syncLostCount), 32'd1);

        $display("[TB] reset in the middle of a frame");
        queueWords(24'h500000, NPIX, 1'b1);
        idle(30);
        for (int p = 0; p < 16; p++) begin
            applyStimulus(1'b1, 11'(p % H), 10'(p / H), 1'b1, 1'b1);
        end
        checkOutput("rgbPixel15", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'h50000F);
        checkOutput("lockedPixel15", 32'(oLOCKED), 32'd1);
        iRST_n = 1'b0;
        @(posedge iCLK);
        #1;
        checkOutput("midRstHD", 32'(oHD), 32'd0);
        checkOutput("midRstVD", 32'(oVD), 32'd0);
        checkOutput("midRstDEN", 32'(oDEN), 32'd0);
        checkOutput("midRstRgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
        checkOutput("midRstLocked", 32'(oLOCKED), 32'd0);
        checkOutput("midRstUnderflow", 32'(oUNDERFLOW), 32'd0);
        checkOutput("midRstFifoEmpty", 32'(dut.uFifo.empty), 32'd1);
        streamQ.delete();
        iRST_n = 1'b1;

        $display("[TB] relock after reset");
        queueWords(24'h600000, NPIX, 1'b1);
        setExp(24'h600000, NPIX);
        idle(30);
        playFrame(1'b0);
        checkOutput("underflowAfterRelock", 32'(oUNDERFLOW), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
